// File: rtl/div_sequencer_pkg.sv
// Shared state encoding, parameter defaults and sizing helper for the divide sequencer.
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32;
  localparam logic [4:0]  DEFAULT_EXC_RD         = 5'd30;
  localparam logic [31:0] DEFAULT_EXC_CODE       = 32'd5;

  // A one-cycle timeout still needs a 1-bit counter.
  function automatic int unsigned counterWidth(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/div_sequencer_timeout_counter.sv
// Counts cycles spent waiting on the divider; terminal count marks the last allowed WAIT cycle.
module timeout_counter
  import div_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int unsigned W = counterWidth(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  // Saturate at the terminal value so a held enable never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/div_sequencer.sv
// Sequences one divide at a time through an external divider: issue, start pulse,
// wait for the result or time out, then a single registered writeback cycle.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [4:0]  EXC_RD         = DEFAULT_EXC_RD,
  parameter logic [31:0] EXC_CODE       = DEFAULT_EXC_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [31:0] issue_dividend,
  input  logic [31:0] issue_divisor,
  input  logic [4:0]  issue_rd,
  output logic        stall,
  output logic        ctrl_DIV,
  output logic [31:0] dividend,
  output logic [31:0] divisor,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic        timeout
);

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [4:0]  r_rd;

  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_exception;
  logic        r_timeout;

  logic        w_capture;
  logic        w_stall;
  logic        w_ctrl_div;
  logic        w_wb_valid;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_wb_data;
  logic        w_wb_exception;
  logic        w_timeout;

  logic        w_cnt_clear;
  logic        w_cnt_enable;
  logic        w_cnt_terminal;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_terminal(w_cnt_terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Writeback values are computed on the WAIT->WB transition and registered,
  // so they appear for exactly the WB cycle and are zero otherwise.
  always_comb begin
    w_next_state   = r_state;
    w_capture      = 1'b0;
    w_stall        = 1'b0;
    w_ctrl_div     = 1'b0;
    w_cnt_clear    = 1'b1;
    w_cnt_enable   = 1'b0;
    w_wb_valid     = 1'b0;
    w_wb_rd        = '0;
    w_wb_data      = '0;
    w_wb_exception = 1'b0;
    w_timeout      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_stall = issue_valid;
        if (issue_valid) begin
          w_capture    = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        w_stall      = 1'b1;
        w_ctrl_div   = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        w_stall      = 1'b1;
        w_cnt_clear  = 1'b0;
        w_cnt_enable = 1'b1;
        if (data_resultRDY) begin
          w_next_state = S_WB;
          if (data_exception) begin
            w_wb_valid     = 1'b1;
            w_wb_rd        = EXC_RD;
            w_wb_data      = EXC_CODE;
            w_wb_exception = 1'b1;
          end else begin
            w_wb_valid = (r_rd != 5'd0);
            w_wb_rd    = r_rd;
            w_wb_data  = data_result;
          end
        end else if (w_cnt_terminal) begin
          w_next_state   = S_WB;
          w_wb_valid     = 1'b1;
          w_wb_rd        = EXC_RD;
          w_wb_data      = EXC_CODE;
          w_wb_exception = 1'b1;
          w_timeout      = 1'b1;
        end
      end
      S_WB: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dividend     <= '0;
      r_divisor      <= '0;
      r_rd           <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_wb_exception <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      if (w_capture) begin
        r_dividend <= issue_dividend;
        r_divisor  <= issue_divisor;
        r_rd       <= issue_rd;
      end
      r_wb_valid     <= w_wb_valid;
      r_wb_rd        <= w_wb_rd;
      r_wb_data      <= w_wb_data;
      r_wb_exception <= w_wb_exception;
      r_timeout      <= w_timeout;
    end
  end

  // Stall follows issue_valid combinationally in IDLE, so it is masked while reset is held.
  assign stall        = w_stall & ~reset;
  assign ctrl_DIV     = w_ctrl_div;
  assign dividend     = r_dividend;
  assign divisor      = r_divisor;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign wb_exception = r_wb_exception;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: fixed vectors, reset and back-to-back sequences, and random ops
// scored against expectations derived from the sequencing rules, with a behavioural divider.
module tb_div_sequencer;

  localparam int          TIMEOUT   = 32;
  localparam logic [4:0]  EXC_RD    = 5'd30;
  localparam logic [31:0] EXC_CODE  = 32'd5;
  localparam int          DIV_DELAY = 23;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [31:0] issue_dividend;
  logic [31:0] issue_divisor;
  logic [4:0]  issue_rd;
  logic        stall;
  logic        ctrl_DIV;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        timeout;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          delay;
    bit          hold;
    int          expWb;
    bit          expValid;
    logic [4:0]  expRd;
    logic [31:0] expData;
    bit          expExc;
    bit          expTo;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          rdyCountdown = -1;
  logic [31:0] pendResult = '0;
  logic        pendExc = 1'b0;
  int          curDelay = DIV_DELAY;

  div_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .EXC_RD        (EXC_RD),
    .EXC_CODE      (EXC_CODE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_dividend(issue_dividend),
    .issue_divisor (issue_divisor),
    .issue_rd      (issue_rd),
    .stall         (stall),
    .ctrl_DIV      (ctrl_DIV),
    .dividend      (dividend),
    .divisor       (divisor),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_exception  (wb_exception),
    .timeout       (timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge and drive the divider's return for that cycle.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
    data_resultRDY = 1'b0;
    data_exception = 1'($urandom_range(0, 1));
    data_result    = $urandom();
    if (rdyCountdown > 0) begin
      rdyCountdown--;
      if (rdyCountdown == 0) begin
        data_resultRDY = 1'b1;
        data_result    = pendResult;
        data_exception = pendExc;
        rdyCountdown   = -1;
      end
    end
  endtask

  // Behavioural divider: a start pulse schedules the signed quotient curDelay cycles later.
  task automatic observeDivider();
    if (ctrl_DIV === 1'b1 && curDelay > 0) begin
      rdyCountdown = curDelay;
      pendExc      = (divisor == 32'd0);
      pendResult   = pendExc ? 32'd0 : 32'($signed(dividend) / $signed(divisor));
    end
  endtask

  function automatic vec_t mkVec(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                                 input int delay, input bit hold, input int expWb, input bit expValid,
                                 input logic [4:0] expRd, input logic [31:0] expData,
                                 input bit expExc, input bit expTo);
    vec_t v;
    v.a = a; v.b = b; v.rd = rd; v.delay = delay; v.hold = hold;
    v.expWb = expWb; v.expValid = expValid; v.expRd = expRd; v.expData = expData;
    v.expExc = expExc; v.expTo = expTo;
    return v;
  endfunction

  // Expected behaviour from the rules: the result arrives at cycle 1+delay and is taken if that
  // falls inside the TIMEOUT waiting cycles (2..TIMEOUT+1); otherwise the op aborts.
  function automatic vec_t refModel(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                                    input int delay, input bit hold);
    vec_t v;
    bit   responds;
    responds   = (delay >= 1) && (delay <= TIMEOUT);
    v.a = a; v.b = b; v.rd = rd; v.delay = delay; v.hold = hold;
    v.expWb    = responds ? 2 + delay : 2 + TIMEOUT;
    v.expTo    = !responds;
    v.expExc   = !responds || (b == 32'd0);
    if (v.expExc) begin
      v.expValid = 1'b1;
      v.expRd    = EXC_RD;
      v.expData  = EXC_CODE;
    end else begin
      v.expValid = (rd != 5'd0);
      v.expRd    = rd;
      v.expData  = 32'($signed(a) / $signed(b));
    end
    return v;
  endfunction

  task automatic runOp(input vec_t v, input int idx);
    int ctrlCount;
    int ctrlCycle;
    int stallErr;
    int earlyWb;
    int operandErr;
    ctrlCount = 0; ctrlCycle = -1; stallErr = 0; earlyWb = 0; operandErr = 0;
    curDelay = v.delay;
    for (int c = 0; c <= v.expWb; c++) begin
      applyStimulus();
      if (c == 0) begin
        issue_valid    = 1'b1;
        issue_dividend = v.a;
        issue_divisor  = v.b;
        issue_rd       = v.rd;
      end else begin
        issue_valid    = v.hold;
        issue_dividend = $urandom();
        issue_divisor  = $urandom();
        issue_rd       = 5'($urandom_range(0, 31));
      end
      @(negedge clock);
      observeDivider();
      if (ctrl_DIV === 1'b1) begin
        ctrlCount++;
        if (ctrlCycle < 0) ctrlCycle = c;
      end
      if (stall !== 1'(c < v.expWb)) stallErr++;
      if (c >= 1 && (dividend !== v.a || divisor !== v.b)) operandErr++;
      if (c < v.expWb && {wb_valid, wb_exception, timeout, wb_rd, wb_data} !== '0) earlyWb++;
      if (c == v.expWb) begin
        checkOutput($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'(v.expValid));
        checkOutput($sformatf("v%0d_wb_exception", idx), 32'(wb_exception), 32'(v.expExc));
        checkOutput($sformatf("v%0d_timeout", idx), 32'(timeout), 32'(v.expTo));
        if (v.expValid) begin
          checkOutput($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), 32'(v.expRd));
          checkOutput($sformatf("v%0d_wb_data", idx), wb_data, v.expData);
        end
      end
    end
    checkOutput($sformatf("v%0d_ctrl_count", idx), 32'(ctrlCount), 32'd1);
    checkOutput($sformatf("v%0d_ctrl_cycle", idx), 32'(ctrlCycle), 32'd1);
    checkOutput($sformatf("v%0d_stall_errors", idx), 32'(stallErr), 32'd0);
    checkOutput($sformatf("v%0d_early_wb", idx), 32'(earlyWb), 32'd0);
    checkOutput($sformatf("v%0d_operand_errors", idx), 32'(operandErr), 32'd0);
  endtask

  initial begin
    vec_t        vecs [11];
    vec_t        v;
    int          activity;
    int          idle;
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;

    vecs[0]  = mkVec(32'd100,        32'd7,  5'd5,  23, 1'b0, 25, 1'b1, 5'd5,  32'd14,        1'b0, 1'b0);
    vecs[1]  = mkVec(32'hFFFFFF9C,   32'd7,  5'd3,  23, 1'b0, 25, 1'b1, 5'd3,  32'hFFFFFFF2,  1'b0, 1'b0);
    vecs[2]  = mkVec(32'd5,          32'd0,  5'd4,  23, 1'b0, 25, 1'b1, 5'd30, 32'd5,         1'b1, 1'b0);
    vecs[3]  = mkVec(32'd50,         32'd5,  5'd6,  35, 1'b0, 34, 1'b1, 5'd30, 32'd5,         1'b1, 1'b1);
    vecs[4]  = mkVec(32'd8,          32'd2,  5'd9,  1,  1'b0, 3,  1'b1, 5'd9,  32'd4,         1'b0, 1'b0);
    vecs[5]  = mkVec(32'd1000,       32'd10, 5'd10, 32, 1'b0, 34, 1'b1, 5'd10, 32'd100,       1'b0, 1'b0);
    vecs[6]  = mkVec(32'd77,         32'd7,  5'd11, 33, 1'b0, 34, 1'b1, 5'd30, 32'd5,         1'b1, 1'b1);
    vecs[7]  = mkVec(32'd12,         32'd4,  5'd0,  23, 1'b1, 25, 1'b0, 5'd0,  32'd0,         1'b0, 1'b0);
    vecs[8]  = mkVec(32'd12,         32'd4,  5'd2,  23, 1'b0, 25, 1'b1, 5'd2,  32'd3,         1'b0, 1'b0);
    vecs[9]  = mkVec(32'd21,         32'd0,  5'd0,  0,  1'b0, 34, 1'b1, 5'd30, 32'd5,         1'b1, 1'b1);
    vecs[10] = mkVec(32'd9,          32'd3,  5'd7,  23, 1'b0, 25, 1'b1, 5'd7,  32'd3,         1'b0, 1'b0);

    reset          = 1'b1;
    issue_valid    = 1'b1;
    issue_dividend = 32'h1234;
    issue_divisor  = 32'd5;
    issue_rd       = 5'd1;
    data_result    = '0;
    data_exception = 1'b0;
    data_resultRDY = 1'b0;

    @(posedge clock);
    #1;
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_ctrl_DIV", 32'(ctrl_DIV), 32'd0);
    checkOutput("reset_dividend", dividend, 32'd0);
    checkOutput("reset_wb", 32'({wb_valid, wb_exception, timeout, wb_rd} != '0) | 32'(wb_data != 32'd0), 32'd0);
    @(negedge clock);
    reset       = 1'b0;
    issue_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i], i);
    end

    // Reset during WAIT cycle 10 (cycle 12 of the op), with issue_valid held high.
    curDelay = DIV_DELAY;
    for (int c = 0; c <= 12; c++) begin
      applyStimulus();
      issue_valid = 1'b1;
      if (c == 0) begin
        issue_dividend = 32'd50;
        issue_divisor  = 32'd5;
        issue_rd       = 5'd8;
      end
      @(negedge clock);
      observeDivider();
    end
    checkOutput("pre_reset_stall", 32'(stall), 32'd1);
    checkOutput("pre_reset_dividend", dividend, 32'd50);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_stall", 32'(stall), 32'd0);
    checkOutput("mid_reset_ctrl_DIV", 32'(ctrl_DIV), 32'd0);
    checkOutput("mid_reset_dividend", dividend, 32'd0);
    checkOutput("mid_reset_divisor", divisor, 32'd0);
    checkOutput("mid_reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("mid_reset_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("mid_reset_wb_data", wb_data, 32'd0);
    checkOutput("mid_reset_wb_exception", 32'(wb_exception), 32'd0);
    checkOutput("mid_reset_timeout", 32'(timeout), 32'd0);
    applyStimulus();
    issue_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // The aborted op's result still arrives; it must leave the idle sequencer untouched.
    activity = 0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus();
      issue_valid = 1'b0;
      @(negedge clock);
      observeDivider();
      if ({stall, ctrl_DIV, wb_valid, wb_exception, timeout, wb_rd, wb_data} !== '0) activity++;
    end
    checkOutput("post_reset_activity", 32'(activity), 32'd0);
    runOp(vecs[10], 10);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom();
        1:       a = 32'(-int'($urandom_range(1, 1000)));
        default: a = 32'($urandom_range(0, 100000));
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom();
        default: b = 32'($urandom_range(1, 100));
      endcase
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 5))
        0:       d = 0;
        1:       d = int'($urandom_range(1, 35));
        default: d = DIV_DELAY;
      endcase
      v = refModel(a, b, rd, d, 1'($urandom_range(0, 1)));
      runOp(v, 100 + n);
      idle = int'($urandom_range(0, 2));
      for (int k = 0; k < idle; k++) begin
        applyStimulus();
        issue_valid = 1'b0;
        @(negedge clock);
        observeDivider();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32: WAIT cycles before abort.
REQ-002 Parameter EXC_RD, default 5'd30: writeback register for exceptions.
REQ-003 Parameter EXC_CODE, default 32'd5: writeback data for exceptions.
REQ-004 clock  in  1: single clock, rising edge.
REQ-005 reset  in  1: asynchronous, active-high.
REQ-006 issue_valid  in  1: pipeline presents a divide.
REQ-007 issue_dividend, issue_divisor  in  32 each: operands.
REQ-008 issue_rd  in  5: destination register.
REQ-009 stall  out  1: holds pipeline.
REQ-010 ctrl_DIV  out  1: start pulse to divider.
REQ-011 dividend, divisor  out  32 each: operands to divider.
REQ-012 data_result  in  32, data_exception  in  1, data_resultRDY  in  1: divider return.
REQ-013 wb_valid  out  1, wb_rd  out  5, wb_data  out  32, wb_exception  out  1: writeback.
REQ-014 timeout  out  1: one-cycle abort flag.

Function
REQ-015 States IDLE, START, WAIT, WB; transitions only on rising clock.
REQ-016 IDLE: issue_valid=1 -> capture operands and issue_rd into holding registers, go START; else stay.
REQ-017 START: ctrl_DIV=1 for exactly this one cycle; go WAIT; data_resultRDY ignored.
REQ-018 WAIT: data_resultRDY=1 -> capture data_result and data_exception, go WB.
REQ-019 WAIT: counter counts from 0 at WAIT entry; at TIMEOUT_CYCLES-1 without data_resultRDY -> go WB as timeout.
REQ-020 data_resultRDY and timeout in the same cycle: data_resultRDY wins, no timeout.
REQ-021 WB: one cycle, then IDLE; timeout=1 in WB only for the timeout case.
REQ-022 dividend/divisor outputs driven from holding registers, stable from START through WB.
REQ-023 stall = issue_valid in IDLE; 1 in START and WAIT; 0 in WB.
REQ-024 Latency: accept at cycle 0, ctrl_DIV at cycle 1, RDY at cycle 1+N, wb_valid at cycle 2+N.
REQ-025 WB normal: wb_rd=held rd, wb_data=captured result, wb_exception=0.
REQ-026 WB exception (data_exception=1 or timeout): wb_rd=EXC_RD, wb_data=EXC_CODE, wb_exception=1.
REQ-027 Held rd of 0 with no exception: wb_valid=0 in WB; the state sequence is otherwise unchanged.
REQ-028 data_resultRDY outside WAIT is ignored, including a stale pulse from an aborted op.
REQ-029 issue_valid is sampled only in IDLE; a new op is accepted the cycle after WB.
REQ-030 wb_* and timeout are registered outputs, zero outside WB.

Reset
REQ-031 reset=1 forces IDLE, clears the counter and holding registers, and zeroes every output immediately, including mid-operation.
REQ-032 After reset release, the first issue_valid is handled per REQ-016.

Structure
REQ-033 Shared package holds the state encoding and the defaults for TIMEOUT_CYCLES, EXC_RD and EXC_CODE.
REQ-034 One sub-module, timeout_counter: width from TIMEOUT_CYCLES; has clear and enable inputs and a terminal-count output.
REQ-035 The divider is external and driven only through ctrl_DIV, dividend and divisor.

Verification
REQ-036 The bench model returns the quotient with data_resultRDY pulsed 23 cycles after ctrl_DIV; data_exception=1 when the divisor is 0.
REQ-037 100/7, rd=5 -> one ctrl_DIV pulse at cycle 1; wb_valid at cycle 25 with wb_rd=5, wb_data=14; stall high cycles 0-24.
REQ-038 -100/7, rd=3 -> wb_data=32'hFFFFFFF2, wb_exception=0.
REQ-039 5/0, rd=4 -> wb_rd=30, wb_data=5, wb_exception=1, timeout=0.
REQ-040 Model silent -> WB after 32 WAIT cycles with timeout=1, wb_exception=1; a late RDY is ignored.
REQ-041 reset pulsed at WAIT cycle 10 -> outputs 0 at once; stale RDY ignored; next issue of 9/3, rd=7 writes 3.
REQ-042 Back-to-back ops, rd=0 then rd=2 -> first op gives no wb_valid; second is accepted the cycle after WB and writes back normally.
